// File: rtl/riscv_shift_sequencer.sv
// Two-requester round-robin front end for the 15-bit-per-pass RV32 barrel shifter.
// Full 0-31 shift amounts are produced by iterating passes through an accumulator.

module riscv_pass_shifter (
    input  logic [31:0] i_data,
    input  logic [3:0]  i_amt,
    input  logic [1:0]  i_type,
    output logic [31:0] o_data
);

    logic [31:0] w_val;
    logic        w_fill;

    // Log-shifter stages of 1/2/4/8; SRA replicates the sign of the pass input.
    always_comb begin
        w_fill = (i_type == 2'b10) && i_data[31];
        w_val  = i_data;
        for (int k = 0; k < 4; k++) begin
            if (i_amt[k] && (i_type != 2'b11)) begin
                if (i_type == 2'b00) begin
                    w_val = w_val << (1 << k);
                end else begin
                    w_val = (w_val >> (1 << k)) |
                            (w_fill ? ~(32'hFFFF_FFFF >> (1 << k)) : 32'd0);
                end
            end
        end
        o_data = w_val;
    end

endmodule

module riscv_shift_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_shamt,
    input  logic [1:0]  req0_type,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_shamt,
    input  logic [1:0]  req1_type,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_id,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_acc;
    logic [4:0]  r_rem;
    logic [1:0]  r_type;
    logic        r_id;
    logic        r_last_grant;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_accept;
    logic        w_sel_id;
    logic [31:0] w_sel_data;
    logic [4:0]  w_sel_shamt;
    logic [1:0]  w_sel_type;
    logic [3:0]  w_step;
    logic [4:0]  w_rem_next;
    logic [31:0] w_shift_out;

    // Contention goes to whichever requester did not win last time.
    assign w_grant0 = req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
    assign w_accept = (r_state == ST_IDLE) && (w_grant0 || w_grant1);
    assign w_sel_id = w_grant1;

    assign w_sel_data  = w_sel_id ? req1_data  : req0_data;
    assign w_sel_shamt = w_sel_id ? req1_shamt : req0_shamt;
    assign w_sel_type  = w_sel_id ? req1_type  : req0_type;

    assign w_step     = (r_rem > 5'd15) ? 4'd15 : r_rem[3:0];
    assign w_rem_next = r_rem - {1'b0, w_step};

    riscv_pass_shifter u_shifter (
        .i_data (r_acc),
        .i_amt  (w_step),
        .i_type (r_type),
        .o_data (w_shift_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if ((w_sel_shamt == 5'd0) || (w_sel_type == 2'b11)) begin
                        w_next_state = ST_RESP;
                    end else begin
                        w_next_state = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (w_rem_next == 5'd0) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Readies are masked by rst_n so nothing is accepted while reset is held.
    always_comb begin
        req0_ready = rst_n && (r_state == ST_IDLE) && w_grant0;
        req1_ready = rst_n && (r_state == ST_IDLE) && w_grant1;
        resp_valid = (r_state == ST_RESP);
        busy       = (r_state != ST_IDLE);
        resp_data  = r_acc;
        resp_id    = r_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc        <= 32'd0;
            r_rem        <= 5'd0;
            r_type       <= 2'b00;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_acc        <= w_sel_data;
                        r_rem        <= w_sel_shamt;
                        r_type       <= w_sel_type;
                        r_id         <= w_sel_id;
                        r_last_grant <= w_sel_id;
                    end
                end
                ST_SHIFT: begin
                    r_acc <= w_shift_out;
                    r_rem <= w_rem_next;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_shift_sequencer.sv
// Self-checking bench for riscv_shift_sequencer: a one-shot shift/latency model
// checked every cycle, plus directed scenarios with literal expectations.

module tb_riscv_shift_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req0Valid, req1Valid;
    logic        req0Ready, req1Ready;
    logic [31:0] req0Data, req1Data;
    logic [4:0]  req0Shamt, req1Shamt;
    logic [1:0]  req0Type, req1Type;
    logic        respValid, respReady;
    logic [31:0] respData;
    logic        respId;
    logic        busy;

    int totalChecks = 0;
    int badChecks   = 0;
    int cycle       = 0;

    riscv_shift_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0Valid),
        .req0_ready (req0Ready),
        .req0_data  (req0Data),
        .req0_shamt (req0Shamt),
        .req0_type  (req0Type),
        .req1_valid (req1Valid),
        .req1_ready (req1Ready),
        .req1_data  (req1Data),
        .req1_shamt (req1Shamt),
        .req1_type  (req1Type),
        .resp_valid (respValid),
        .resp_ready (respReady),
        .resp_data  (respData),
        .resp_id    (respId),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference: the whole RV32 shift in one step, independent of pass splitting.
    function automatic logic [31:0] refShift(input logic [31:0] d, input logic [4:0] s,
                                             input logic [1:0] t);
        case (t)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 32'($signed(d) >>> s);
            default: return d;
        endcase
    endfunction

    function automatic int refPasses(input logic [4:0] s, input logic [1:0] t);
        if (t == 2'b11) return 0;
        return (int'(s) + 14) / 15;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int n, input logic v, input logic [31:0] d,
                                 input logic [4:0] s, input logic [1:0] t);
        if (n == 0) begin
            req0Valid = v; req0Data = d; req0Shamt = s; req0Type = t;
        end else begin
            req1Valid = v; req1Data = d; req1Shamt = s; req1Type = t;
        end
    endtask

    // Model state: at most one operation in flight, plus the fairness pointer.
    bit          mPending   = 0;
    bit          mId        = 0;
    logic [31:0] mData      = 0;
    int          mDue       = 0;
    bit          mLastGrant = 1;

    always @(negedge clk) begin
        bit g0, g1;
        checkOutput("ready_exclusive", 32'(req0Ready && req1Ready), 32'd0);
        if (!rst_n) begin
            mPending   = 0;
            mLastGrant = 1;
            checkOutput("rst_resp_valid", 32'(respValid), 32'd0);
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_resp_data", respData, 32'd0);
            checkOutput("rst_resp_id", 32'(respId), 32'd0);
            checkOutput("rst_ready0", 32'(req0Ready), 32'd0);
            checkOutput("rst_ready1", 32'(req1Ready), 32'd0);
        end else if (mPending) begin
            checkOutput("busy_ready0", 32'(req0Ready), 32'd0);
            checkOutput("busy_ready1", 32'(req1Ready), 32'd0);
            checkOutput("busy_flag", 32'(busy), 32'd1);
            if (cycle < mDue) begin
                checkOutput("early_resp_valid", 32'(respValid), 32'd0);
            end else begin
                checkOutput("resp_valid", 32'(respValid), 32'd1);
                checkOutput("resp_data", respData, mData);
                checkOutput("resp_id", 32'(respId), 32'(mId));
                if (respValid && respReady) mPending = 0;
            end
        end else begin
            g0 = req0Valid && (!req1Valid || mLastGrant);
            g1 = req1Valid && (!req0Valid || !mLastGrant);
            checkOutput("idle_resp_valid", 32'(respValid), 32'd0);
            checkOutput("idle_busy", 32'(busy), 32'd0);
            checkOutput("arb_ready0", 32'(req0Ready), 32'(g0));
            checkOutput("arb_ready1", 32'(req1Ready), 32'(g1));
            if (g0 || g1) begin
                mPending   = 1;
                mId        = g1;
                mLastGrant = g1;
                mData      = g1 ? refShift(req1Data, req1Shamt, req1Type)
                                : refShift(req0Data, req0Shamt, req0Type);
                mDue       = cycle + 1 + (g1 ? refPasses(req1Shamt, req1Type)
                                             : refPasses(req0Shamt, req0Type));
            end
        end
    end

    task automatic runOne(input string name, input int n, input logic [31:0] d,
                          input logic [4:0] s, input logic [1:0] t,
                          input logic [31:0] expData, input int expShifts);
        bit got = 0;
        int shifts = 0;
        @(posedge clk); #1;
        respReady = 1'b1;
        applyStimulus(n, 1'b1, d, s, t);
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = (n == 0) ? req0Ready : req1Ready;
        end
        checkOutput({name, "_granted"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        applyStimulus(n, 1'b0, $urandom, 5'($urandom), 2'($urandom));
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (respValid) got = 1;
            else shifts++;
        end
        checkOutput({name, "_resp_seen"}, 32'(got), 32'd1);
        checkOutput({name, "_shift_cycles"}, 32'(shifts), 32'(expShifts));
        checkOutput({name, "_data"}, respData, expData);
        checkOutput({name, "_id"}, 32'(respId), 32'(n));
    endtask

    initial begin
        int order[$];
        bit got;
        rst_n = 1'b0;
        respReady = 1'b1;
        applyStimulus(0, 1'b0, 32'd0, 5'd0, 2'd0);
        applyStimulus(1, 1'b0, 32'd0, 5'd0, 2'd0);

        checkOutput("pin_sll31", refShift(32'h1, 5'd31, 2'b00), 32'h8000_0000);
        checkOutput("pin_sra16", refShift(32'h8000_0000, 5'd16, 2'b10), 32'hFFFF_8000);
        checkOutput("pin_passes31", 32'(refPasses(5'd31, 2'b00)), 32'd3);
        checkOutput("pin_passes16", 32'(refPasses(5'd16, 2'b10)), 32'd2);

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        runOne("sll31", 0, 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 3);
        runOne("sra16", 1, 32'h8000_0000, 5'd16, 2'b10, 32'hFFFF_8000, 2);
        runOne("zero", 0, 32'hDEAD_BEEF, 5'd0, 2'b01, 32'hDEAD_BEEF, 0);
        runOne("pass20", 1, 32'h1234_5678, 5'd20, 2'b11, 32'h1234_5678, 0);
        runOne("sra30", 0, 32'hF000_0000, 5'd30, 2'b10, 32'hFFFF_FFFF, 2);

        // Both requesters hammer continuously; accepts must alternate.
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 32'h0000_0003, 5'd1, 2'b00);
        applyStimulus(1, 1'b1, 32'h0000_0008, 5'd1, 2'b01);
        for (int k = 0; k < 100 && order.size() < 6; k++) begin
            @(negedge clk);
            if (req0Ready) order.push_back(0);
            else if (req1Ready) order.push_back(1);
        end
        applyStimulus(0, 1'b0, 32'd0, 5'd0, 2'd0);
        applyStimulus(1, 1'b0, 32'd0, 5'd0, 2'd0);
        checkOutput("rr_accepts", 32'(order.size()), 32'd6);
        for (int i = 1; i < order.size(); i++)
            checkOutput("rr_alternate", 32'(order[i]), 32'(1 - order[i-1]));
        repeat (5) @(posedge clk);

        // Backpressure: response must hold and no request may be accepted.
        #1 respReady = 1'b0;
        applyStimulus(1, 1'b1, 32'hA5A5_0F0F, 5'd5, 2'b01);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = req1Ready;
        end
        @(posedge clk); #1;
        applyStimulus(1, 1'b0, 32'd0, 5'd0, 2'd0);
        applyStimulus(0, 1'b1, 32'h5555_5555, 5'd3, 2'b00);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = respValid;
        end
        checkOutput("bp_resp_seen", 32'(got), 32'd1);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_data", respData, 32'h052D_2878);
            checkOutput("bp_id", 32'(respId), 32'd1);
            checkOutput("bp_ready0", 32'(req0Ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 32'd0, 5'd0, 2'd0);
        respReady = 1'b1;
        repeat (4) @(posedge clk);

        // Reset in the middle of a 3-pass operation discards it.
        #1 applyStimulus(0, 1'b1, 32'h0000_0001, 5'd31, 2'b00);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = req0Ready;
        end
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 32'd0, 5'd0, 2'd0);
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 32'hFFFF_FFFF, 5'd7, 2'b00);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_valid", 32'(respValid), 32'd0);
        checkOutput("async_rst_data", respData, 32'd0);
        checkOutput("async_rst_ready0", 32'(req0Ready), 32'd0);
        repeat (3) @(posedge clk);
        applyStimulus(0, 1'b0, 32'd0, 5'd0, 2'd0);
        #2 rst_n = 1'b1;
        runOne("post_rst", 0, 32'h0000_0001, 5'd4, 2'b00, 32'h0000_0010, 1);

        // Random traffic, checked entirely by the per-cycle model.
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            applyStimulus(0, 1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                          2'($urandom_range(0, 3)));
            applyStimulus(1, 1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                          2'($urandom_range(0, 3)));
            respReady = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 32'd0, 5'd0, 2'd0);
        applyStimulus(1, 1'b0, 32'd0, 5'd0, 2'd0);
        respReady = 1'b1;
        repeat (10) @(posedge clk);
        checkOutput("drained", 32'(mPending), 32'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
